mixer_tdm: RTL and testbench

Time-multiplexed, parametrised voice mixer between the oscillator bank and the output/effects chain. On a sample strobe it snapshots all channel samples, per-channel gains, enable mask and master volume. It then accumulates one channel per clock through a single multiplier, applies master volume and optional voice-count normalisation, and saturates the result to the output width. The result is presented with a one-cycle valid pulse.

---
 rtl/mixer_tdm.sv | 228 ++++++++++++++++++++++
 tb/tb_mixer_tdm.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mixer_tdm.sv
// Time-multiplexed voice mixer: one channel per clock through a single multiplier,
// then master volume, optional voice-count normalisation (MIXER_NORMALISE_EN), saturation.
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 4
`endif

module mixer_tdm #(
  parameter int WIDTH      = 24,
  parameter int N_CHANNELS = `N_OSCILLATORS,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  sample_valid,
  output logic                                  sample_ready,
  input  logic [N_CHANNELS-1:0][WIDTH-1:0]      waves,
  input  logic [N_CHANNELS-1:0][GAIN_WIDTH-1:0] gains,
  input  logic [N_CHANNELS-1:0]                 enable,
  input  logic [GAIN_WIDTH-1:0]                 master_volume,
  output logic [WIDTH-1:0]                      out,
  output logic                                  out_valid,
  output logic                                  clip,
  output logic                                  overrun
);
  localparam int IW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int PW = WIDTH + GAIN_WIDTH + 1;
  localparam int AW = WIDTH + GAIN_WIDTH + $clog2(N_CHANNELS) + 1;
  localparam int SW = AW + GAIN_WIDTH + 1;
  localparam int VW = WIDTH + 2;
`ifdef MIXER_NORMALISE_EN
  localparam int DIV_W = WIDTH + 4 + $clog2(N_CHANNELS + 1);
  localparam int NW    = $clog2(N_CHANNELS + 1);
  localparam int DVW   = $clog2(N_CHANNELS + 3) + 1;
  localparam int CW    = $clog2(DIV_W);
  localparam int RW    = DIV_W + 1;
  typedef enum logic [2:0] {IDLE, ACCUM, SCALE, NORM, OUTPUT} state_t;
`else
  localparam int RW    = VW;
  typedef enum logic [2:0] {IDLE, ACCUM, SCALE, OUTPUT} state_t;
`endif
  localparam logic signed [SW-1:0] VMAX = SW'((64'sd1 <<< (VW - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] VMIN = ~VMAX;
  localparam logic signed [RW-1:0] OMAX = RW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] OMIN = ~OMAX;

  state_t                                state_q, state_d;
  logic [N_CHANNELS-1:0][WIDTH-1:0]      waves_q, waves_d;
  logic [N_CHANNELS-1:0][GAIN_WIDTH-1:0] gains_q, gains_d;
  logic [N_CHANNELS-1:0]                 en_q, en_d;
  logic [GAIN_WIDTH-1:0]                 mv_q, mv_d;
  logic signed [AW-1:0]                  acc_q, acc_d;
  logic [IW-1:0]                         idx_q, idx_d;
  logic [WIDTH-1:0]                      out_q, out_d;
  logic                                  clip_q, clip_d, ovalid_q, ovalid_d, overrun_q, overrun_d;

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_sh;
  logic signed [SW-1:0] scaled;
  logic signed [VW-1:0] v_cl;
  logic signed [RW-1:0] res;

`ifdef MIXER_NORMALISE_EN
  logic [DIV_W-1:0]     dq_q, dq_d;   // dividend shifts out the top, quotient shifts in the bottom
  logic [DVW-1:0]       rem_q, rem_d, den_q, den_d, rem_sh;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d, nz_q, nz_d;
  logic [NW-1:0]        n;
  logic [RW-1:0]        tn;
  logic signed [RW-1:0] p;
  logic [DIV_W-1:0]     pmag;
`else
  logic signed [VW-1:0] v_q, v_d;
`endif

  always_comb begin
    prod   = PW'($signed(waves_q[idx_q])) * $signed(PW'({1'b0, gains_q[idx_q]}));
    acc_sh = acc_q >>> (GAIN_WIDTH - 1);
    scaled = (SW'(acc_sh) * $signed(SW'({1'b0, mv_q}))) >>> (GAIN_WIDTH - 1);
    if (scaled > VMAX)      v_cl = VMAX[VW-1:0];
    else if (scaled < VMIN) v_cl = VMIN[VW-1:0];
    else                    v_cl = scaled[VW-1:0];
`ifdef MIXER_NORMALISE_EN
    n = '0;
    for (int i = 0; i < N_CHANNELS; i++) n = n + NW'(en_q[i]);
    tn     = RW'(n) * RW'(2'd3);
    p      = RW'(v_cl) * $signed(tn);
    pmag   = DIV_W'(p[RW-1] ? -p : p);
    rem_sh = {rem_q[DVW-2:0], dq_q[DIV_W-1]};
    if (!nz_q)      res = '0;
    else if (neg_q) res = -$signed(RW'(dq_q));
    else            res = $signed(RW'(dq_q));
`else
    res = v_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    waves_d   = waves_q;
    gains_d   = gains_q;
    en_d      = en_q;
    mv_d      = mv_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    out_d     = out_q;
    clip_d    = clip_q;
    ovalid_d  = 1'b0;
    overrun_d = sample_valid && (state_q != IDLE);
`ifdef MIXER_NORMALISE_EN
    dq_d  = dq_q;
    rem_d = rem_q;
    den_d = den_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    nz_d  = nz_q;
`else
    v_d = v_q;
`endif
    case (state_q)
      IDLE: if (sample_valid) begin
        waves_d = waves;
        gains_d = gains;
        en_d    = enable;
        mv_d    = master_volume;
        acc_d   = '0;
        idx_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (en_q[idx_q]) acc_d = acc_q + AW'(prod);
        if (idx_q == IW'(N_CHANNELS - 1)) state_d = SCALE;
        else                              idx_d   = idx_q + IW'(1);
      end
      SCALE: begin
`ifdef MIXER_NORMALISE_EN
        dq_d    = pmag;
        rem_d   = '0;
        den_d   = DVW'(n) + DVW'(2);
        cnt_d   = '0;
        neg_d   = p[RW-1];
        nz_d    = (n != '0);
        state_d = NORM;
`else
        v_d     = v_cl;
        state_d = OUTPUT;
`endif
      end
`ifdef MIXER_NORMALISE_EN
      NORM: begin
        // n=0 still runs the full divide so latency never depends on the mask
        rem_d = (rem_sh >= den_q) ? rem_sh - den_q : rem_sh;
        dq_d  = {dq_q[DIV_W-2:0], (rem_sh >= den_q)};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV_W - 1)) state_d = OUTPUT;
      end
`endif
      OUTPUT: begin
        if (res > OMAX) begin
          out_d  = OMAX[WIDTH-1:0];
          clip_d = 1'b1;
        end else if (res < OMIN) begin
          out_d  = OMIN[WIDTH-1:0];
          clip_d = 1'b1;
        end else begin
          out_d  = res[WIDTH-1:0];
          clip_d = 1'b0;
        end
        ovalid_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      waves_q   <= '0;
      gains_q   <= '0;
      en_q      <= '0;
      mv_q      <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      out_q     <= '0;
      clip_q    <= 1'b0;
      ovalid_q  <= 1'b0;
      overrun_q <= 1'b0;
`ifdef MIXER_NORMALISE_EN
      dq_q  <= '0;
      rem_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      nz_q  <= 1'b0;
`else
      v_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      waves_q   <= waves_d;
      gains_q   <= gains_d;
      en_q      <= en_d;
      mv_q      <= mv_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      clip_q    <= clip_d;
      ovalid_q  <= ovalid_d;
      overrun_q <= overrun_d;
`ifdef MIXER_NORMALISE_EN
      dq_q  <= dq_d;
      rem_q <= rem_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      nz_q  <= nz_d;
`else
      v_q <= v_d;
`endif
    end
  end

  assign sample_ready = (state_q == IDLE);
  assign out          = out_q;
  assign out_valid    = ovalid_q;
  assign clip         = clip_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_mixer_tdm.sv
// Directed bench for mixer_tdm: hand-computed sums, saturation, masking, latency,
// overrun and mid-sample reset; expectations follow MIXER_NORMALISE_EN when defined.
module tb_mixer_tdm;
  localparam int N = 4, W = 24, G = 8;
`ifdef MIXER_NORMALISE_EN
  localparam int LAT  = N + 2 + W + 4 + $clog2(N + 1);
  localparam bit NORM = 1'b1;
`else
  localparam int LAT  = N + 2;
  localparam bit NORM = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst, sample_valid, sample_ready;
  logic [N-1:0][W-1:0]  waves;
  logic [N-1:0][G-1:0]  gains;
  logic [N-1:0]         enable;
  logic [G-1:0]         master_volume;
  logic [W-1:0]         out;
  logic                 out_valid, clip, overrun;
  int                   tests = 0, fails = 0;

  mixer_tdm #(.WIDTH(W), .N_CHANNELS(N), .GAIN_WIDTH(G)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .waves(waves), .gains(gains), .enable(enable), .master_volume(master_volume),
    .out(out), .out_valid(out_valid), .clip(clip), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves at the negedge after the cycle following out_valid.
  task automatic run_sample(input string tag, input logic [N-1:0][W-1:0] w,
                            input logic [N-1:0][G-1:0] g, input logic [N-1:0] en,
                            input logic [G-1:0] mv, input int exp_out, input bit exp_clip,
                            input int ovr_edge);
    int lat;
    lat = -1;
    waves = w; gains = g; enable = en; master_volume = mv; sample_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    sample_valid = 1'b0;
    check({tag, " ready_low"}, sample_ready, 0);
    // scramble inputs: only the values latched at acceptance may matter
    waves = {N{24'h5A5A5A}}; gains = '1; enable = '1; master_volume = '1;
    if (ovr_edge == 1) sample_valid = 1'b1;
    for (int e = 1; e <= LAT + 20 && lat < 0; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == ovr_edge) begin
        check({tag, " overrun"}, overrun, 1);
        sample_valid = 1'b0;
      end
      if (out_valid) lat = e;
      if (e + 1 == ovr_edge) sample_valid = 1'b1;
    end
    check({tag, " latency"}, lat, LAT);
    check({tag, " out"}, $signed(out), exp_out);
    check({tag, " clip"}, clip, exp_clip);
    check({tag, " ready_high"}, sample_ready, 1);
    @(posedge clk); @(negedge clk);
    check({tag, " valid_pulse"}, out_valid, 0);
    check({tag, " out_held"}, $signed(out), exp_out);
    check({tag, " no_overrun"}, overrun, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0][W-1:0] w;
    logic [N-1:0][G-1:0] g;
    int hits;
    g = {N{8'd128}};
    rst = 1'b1; sample_valid = 1'b0; waves = '0; gains = '0; enable = '0; master_volume = '0;
    @(negedge clk); @(negedge clk);
    check("rst out", $signed(out), 0);
    check("rst out_valid", out_valid, 0);
    check("rst clip", clip, 0);
    check("rst overrun", overrun, 0);
    check("rst ready", sample_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    w = '0; w[0] = 24'd1000;
    run_sample("ch0_1000", w, g, 4'b0001, 8'd128, 1000, 1'b0, 0);
    w = {N{24'd1000}};
    run_sample("all_1000", w, g, 4'b1111, 8'd128, NORM ? 8000 : 4000, 1'b0, 0);
    run_sample("mv64", w, g, 4'b1111, 8'd64, NORM ? 4000 : 2000, 1'b0, 0);
    w = {N{24'h7FFFFF}};
    run_sample("sat_pos", w, g, 4'b1111, 8'd128, 8388607, 1'b1, 0);
    w[0] = 24'd5;
    run_sample("ch0_5", w, g, 4'b0001, 8'd128, 5, 1'b0, 0);
    w = '0; w[0] = -24'sd1001;
    g[0] = 8'd64;
    run_sample("neg_floor", w, g, 4'b0001, 8'd128, -501, 1'b0, 0);
    g = {N{8'd128}};
    w = {N{24'h800000}};
    run_sample("sat_neg", w, g, 4'b1111, 8'd128, -8388608, 1'b1, 0);
    w = {N{24'd1000}};
    run_sample("mask0", w, g, 4'b0000, 8'd128, 0, 1'b0, 0);
    w = '0; w[0] = 24'd1000;
    run_sample("overrun", w, g, 4'b0001, 8'd128, 1000, 1'b0, 3);

    // reset pulsed around edge 2 of an in-flight sample
    w = {N{24'd777}};
    waves = w; gains = g; enable = 4'b1111; master_volume = 8'd128; sample_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    sample_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("midrst out", $signed(out), 0);
    check("midrst ready", sample_ready, 1);
    check("midrst clip", clip, 0);
    hits = 0;
    for (int e = 0; e < LAT + 4; e++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) hits++;
    end
    check("midrst no_valid", hits, 0);

    w = '0; w[1] = 24'd300; w[2] = -24'sd100;
    run_sample("after_rst", w, g, 4'b0110, 8'd128, NORM ? 300 : 200, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
